// File: rtl/dc_scan_if.sv
// Command/beat bundle for dc_scan; master drives commands and flow control, slave returns beats.
// Parameterised by address width N; the beat bus is 2**N wide.
interface dc_scan_if #(parameter int N = 6);
    logic               en;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_addr;
    logic [N-1:0]       in_count;
    logic [1:0]         in_mode;
    logic [(1<<N)-1:0]  y;
    logic               y_valid;
    logic               done;
    logic [N-1:0]       cur_addr;

    modport master (
        output en, abort, in_valid, in_addr, in_count, in_mode,
        input  in_ready, y, y_valid, done, cur_addr
    );

    modport slave (
        input  en, abort, in_valid, in_addr, in_count, in_mode,
        output in_ready, y, y_valid, done, cur_addr
    );
endinterface

// File: rtl/dc_scan.sv
// Address scanner: emits in_count+1 one-hot/thermometer beats stepping up or down from in_addr.
// Latency: first beat the cycle after acceptance; one idle cycle between back-to-back commands.
// Backpressure: en low stalls the scan in place; abort cancels at once and blocks acceptance.
module dc_scan #(
    parameter int N = 6
) (
    input  logic   clk,
    input  logic   rst_n,
    dc_scan_if.slave bus
);
    localparam int W = 1 << N;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   cur_q;
    logic [N-1:0]   rem_q;
    logic [1:0]     mode_q;
    logic           accept;
    logic           beat;
    logic [W-1:0]   onehot;

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        beat         = 1'b0;
        bus.in_ready = 1'b0;
        bus.y_valid  = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = !bus.abort;
                accept       = bus.in_valid && !bus.abort;
                if (accept) state_d = RUN;
            end
            RUN: begin
                beat        = bus.en && !bus.abort;
                bus.y_valid = beat;
                bus.done    = beat && (rem_q == '0);
                if (bus.abort || bus.done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Thermometer is onehot*2-1; at the top address the shift overflows to 0 and yields all ones.
    always_comb begin
        onehot = W'(1) << cur_q;
        bus.y  = '0;
        if (bus.y_valid) bus.y = mode_q[1] ? ((onehot << 1) - W'(1)) : onehot;
    end

    assign bus.cur_addr = cur_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cur_q  <= bus.in_addr;
                rem_q  <= bus.in_count;
                mode_q <= bus.in_mode;
            end else if (beat) begin
                cur_q <= mode_q[0] ? (cur_q - N'(1)) : (cur_q + N'(1));
                rem_q <= rem_q - N'(1);
            end
        end
    end
endmodule

// File: tb/tb_dc_scan.sv
// Directed bench for dc_scan at N=6, N=3 and N=4; inputs driven on the falling edge, outputs sampled 1 ns later.
module tb_dc_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dc_scan_if #(.N(6)) b6 ();
    dc_scan_if #(.N(3)) b3 ();
    dc_scan_if #(.N(4)) b4 ();

    dc_scan #(.N(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));
    dc_scan #(.N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    dc_scan #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    logic [5:0] a6;
    logic [63:0] exp_y;
    int nbeats;
    logic [7:0] c_y [3]   = '{8'b0000_0011, 8'b0000_0001, 8'b1111_1111};
    logic [2:0] c_a [3]   = '{3'd1, 3'd0, 3'd7};
    logic       d_en [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] d_y [7]  = '{16'h1, 16'h0, 16'h0, 16'h2, 16'h4, 16'h8, 16'h0};
    logic       d_dn [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        {b6.en, b6.abort, b6.in_valid} = '0; b6.in_addr = '0; b6.in_count = '0; b6.in_mode = '0;
        {b3.en, b3.abort, b3.in_valid} = '0; b3.in_addr = '0; b3.in_count = '0; b3.in_mode = '0;
        {b4.en, b4.abort, b4.in_valid} = '0; b4.in_addr = '0; b4.in_count = '0; b4.in_mode = '0;

        #1;
        check("rst_in_ready", 64'(b6.in_ready), 64'd1);
        check("rst_y_valid",  64'(b6.y_valid),  64'd0);
        check("rst_y",        b6.y,             64'd0);
        check("rst_done",     64'(b6.done),     64'd0);
        check("rst_cur_addr", 64'(b6.cur_addr), 64'd0);
        #20;
        @(negedge clk); rst_n = 1'b1;

        // single beat
        @(negedge clk);
        b6.en = 1'b1; b6.in_valid = 1'b1; b6.in_addr = 6'd5; b6.in_count = 6'd0; b6.in_mode = 2'b00;
        #1 check("single_acc_rdy", 64'(b6.in_ready), 64'd1);
        @(negedge clk);
        b6.in_valid = 1'b0; b6.in_addr = 6'h3f; b6.in_mode = 2'b11; b6.in_count = 6'h3f;
        #1;
        check("single_y",       b6.y,             64'h20);
        check("single_y_valid", 64'(b6.y_valid),  64'd1);
        check("single_done",    64'(b6.done),     64'd1);
        check("single_cur",     64'(b6.cur_addr), 64'd5);
        @(negedge clk); #1;
        check("single_rdy_after", 64'(b6.in_ready), 64'd1);
        check("single_idle_y",    b6.y,             64'd0);

        // up wrap across 63 -> 0
        b6.in_valid = 1'b1; b6.in_addr = 6'd62; b6.in_count = 6'd3; b6.in_mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b6.in_valid = 1'b0; b6.in_addr = 6'd9; b6.in_mode = 2'b11;
            #1;
            a6 = 6'(62 + i);
            exp_y = 64'd1 << a6;
            check("wrap_y",    b6.y,             exp_y);
            check("wrap_done", 64'(b6.done),     64'(i == 3));
            check("wrap_cur",  64'(b6.cur_addr), 64'(a6));
        end
        @(negedge clk); #1;
        check("wrap_end_valid", 64'(b6.y_valid), 64'd0);

        // abort during beat 2, then a fresh thermometer command
        b6.in_valid = 1'b1; b6.in_addr = 6'd10; b6.in_count = 6'd3; b6.in_mode = 2'b00;
        @(negedge clk); b6.in_valid = 1'b0; #1;
        check("abort_beat1_y", b6.y, 64'd1 << 10);
        @(negedge clk); b6.abort = 1'b1; #1;
        check("abort_y",       b6.y,             64'd0);
        check("abort_y_valid", 64'(b6.y_valid),  64'd0);
        check("abort_done",    64'(b6.done),     64'd0);
        check("abort_rdy",     64'(b6.in_ready), 64'd0);
        @(negedge clk); b6.abort = 1'b0; #1;
        check("abort_rdy_next",  64'(b6.in_ready), 64'd1);
        check("abort_idle_valid", 64'(b6.y_valid), 64'd0);
        b6.in_valid = 1'b1; b6.in_addr = 6'd20; b6.in_count = 6'd0; b6.in_mode = 2'b10;
        @(negedge clk); b6.in_valid = 1'b0; #1;
        check("abort_new_y",    b6.y,             (64'd1 << 21) - 64'd1);
        check("abort_new_done", 64'(b6.done),     64'd1);
        check("abort_new_cur",  64'(b6.cur_addr), 64'd20);

        // abort in IDLE blocks acceptance
        @(negedge clk); b6.abort = 1'b1; b6.in_valid = 1'b1; b6.in_addr = 6'd7; #1;
        check("idle_abort_rdy", 64'(b6.in_ready), 64'd0);
        @(negedge clk); b6.abort = 1'b0; b6.in_valid = 1'b0; #1;
        check("idle_abort_noacc", 64'(b6.y_valid), 64'd0);

        // down thermometer with wrap, N=3
        b3.en = 1'b1; b3.in_valid = 1'b1; b3.in_addr = 3'd1; b3.in_count = 3'd2; b3.in_mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); b3.in_valid = 1'b0; b3.in_addr = 3'd4; #1;
            check("down_y",    64'(b3.y),        64'(c_y[i]));
            check("down_cur",  64'(b3.cur_addr), 64'(c_a[i]));
            check("down_done", 64'(b3.done),     64'(i == 2));
        end

        // stall with en low, N=4
        @(negedge clk);
        b4.en = 1'b1; b4.in_valid = 1'b1; b4.in_addr = 4'd0; b4.in_count = 4'd3; b4.in_mode = 2'b00;
        nbeats = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); b4.in_valid = 1'b0; b4.en = d_en[i]; #1;
            check("stall_y",    64'(b4.y),    64'(d_y[i]));
            check("stall_done", 64'(b4.done), 64'(d_dn[i]));
            if (b4.y_valid) nbeats++;
        end
        check("stall_beats", 64'(nbeats), 64'd4);

        // reset mid-scan, N=4
        b4.en = 1'b1; b4.in_valid = 1'b1; b4.in_addr = 4'd0; b4.in_count = 4'd3; b4.in_mode = 2'b00;
        @(negedge clk); b4.in_valid = 1'b0; #1;
        check("rstmid_beat1", 64'(b4.y), 64'h1);
        @(negedge clk); rst_n = 1'b0; #1;
        check("rstmid_y",       64'(b4.y),       64'd0);
        check("rstmid_y_valid", 64'(b4.y_valid), 64'd0);
        check("rstmid_done",    64'(b4.done),    64'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rstmid_rdy", 64'(b4.in_ready), 64'd1);
        b4.in_valid = 1'b1; b4.in_addr = 4'd9; b4.in_count = 4'd0;
        @(negedge clk); b4.in_valid = 1'b0; #1;
        check("rstmid_new_y",    64'(b4.y),    64'd1 << 9);
        check("rstmid_new_done", 64'(b4.done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dc_scan.md
DC_SCAN -- requirements
Module: dc_scan

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter: N, 6, address width; output width SHALL be 2**N.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: en  input  1  output enable and scan advance qualifier.
REQ-006 Port: abort  input  1  synchronous command cancel.
REQ-007 Port: in_valid  input  1  command offered.
REQ-008 Port: in_ready  output  1  command accepted when in_valid and in_ready are both high at a rising edge.
REQ-009 Port: in_addr  input  N  start address.
REQ-010 Port: in_count  input  N  number of beats minus one.
REQ-011 Port: in_mode  input  2  bit0 = direction (0 up, 1 down); bit1 = pattern (0 one-hot, 1 thermometer).
REQ-012 Port: y  output  2**N  decoded pattern.
REQ-013 Port: y_valid  output  1  y carries a beat this cycle.
REQ-014 Port: done  output  1  high with the last beat of a command.
REQ-015 Port: cur_addr  output  N  address of the current beat.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 in_ready SHALL be high only in IDLE with abort low.
REQ-018 On acceptance, the block SHALL register in_addr into cur, in_count into rem and in_mode, and SHALL enter RUN.
REQ-019 In RUN, y_valid SHALL equal en and not abort; y, y_valid and done SHALL be combinational from registered state and en/abort.
REQ-020 One-hot pattern: y SHALL have only bit cur set. Thermometer pattern: y SHALL have bits cur down to 0 set.
REQ-021 When y_valid is low, y SHALL be all zeros.
REQ-022 A beat SHALL complete at a rising edge in RUN with y_valid high; then cur SHALL step by +1 (up) or -1 (down), modulo 2**N, and rem SHALL decrement.
REQ-023 Wrap-around: cur SHALL go from 2**N-1 to 0 (up) and from 0 to 2**N-1 (down) with no gap beat.
REQ-024 done SHALL be high only when y_valid is high and rem equals 0; completion of that beat SHALL return the FSM to IDLE.
REQ-025 A command SHALL produce exactly in_count+1 beats. The first beat SHALL be possible in the cycle after acceptance.
REQ-026 The earliest next acceptance SHALL be in the cycle after the last beat, giving a one-cycle bubble between back-to-back commands.
REQ-027 en low in RUN SHALL hold cur, rem and the state. No beat SHALL be skipped or repeated.
REQ-028 abort high SHALL force y_valid and done low in the same cycle and SHALL move the FSM to IDLE at the next edge.
REQ-029 abort in IDLE SHALL block acceptance. abort SHALL take priority over en and in_valid.
REQ-030 cur_addr SHALL equal cur in all states; in IDLE it SHALL hold the last value.
REQ-031 in_addr, in_count and in_mode SHALL be ignored except at acceptance.

Reset
REQ-032 rst_n low SHALL, asynchronously, set state to IDLE, cur, rem and mode to 0, y to 0, and y_valid and done to 0; in_ready SHALL read 1 once abort is low.
REQ-033 Reset asserted mid-RUN SHALL discard the command with no done pulse; the first edge after release SHALL be able to accept a command.

Verification
REQ-034 Reset mid-scan: rst_n low during beat 2 of 4 -> y=0, y_valid=0, done=0 in the same cycle; in_ready=1 after release.
REQ-035 Single beat, N=6: addr=5, count=0, mode=00, en=1 -> next cycle y=64'h20, y_valid=1, done=1; in_ready=1 the cycle after.
REQ-036 Up wrap, N=6: addr=62, count=3, mode=00 -> beats with one-hot bits 62, 63, 0, 1 on consecutive cycles; done on the 4th beat only.
REQ-037 Down thermometer, N=3: addr=1, count=2, mode=11 -> y = 8'b00000011, 8'b00000001, 8'b11111111; cur_addr = 1, 0, 7.
REQ-038 Stall: N=4, addr=0, count=3, up one-hot, en low for 2 cycles after beat 1 -> two cycles of y=0, y_valid=0; then beats at bits 1, 2, 3 with done on bit 3; total 4 beats.
REQ-039 Abort: abort high during beat 2 -> y=0, no done; in_ready=1 next cycle; a new command is accepted and its first beat matches its in_addr.
